// File: rtl/screen_uart_pkg.sv
// Shared constants and FSM encoding for the screen link UART (tx and rx).
package screen_uart_pkg;

  // Bit period at 29.4912 MHz: 246 clocks, about 119.9 kbaud.
  localparam int CLKS_PER_BIT  = 246;
  localparam int FRAME_BITS_P  = 11;  // start, 8 data, parity, stop
  localparam int FRAME_BITS_NP = 10;  // start, 8 data, stop

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TAIL  = 2'd3
  } tx_state_e;

  // Line order, LSB first out: {stop, parity, data[7:0], start}.
  // Without parity the parity slot becomes a second idle-high bit that is
  // never sent, so one 11-bit shifter serves both frame formats.
  function automatic logic [10:0] build_frame(input logic [7:0] data,
                                              input logic       parity_en,
                                              input logic       parity_odd);
    logic par;
    par = (^data) ^ parity_odd;
    if (parity_en) return {1'b1, par, data, 1'b0};
    else           return {1'b1, 1'b1, data, 1'b0};
  endfunction

endpackage

// File: rtl/screen_baud_tick.sv
// Clear-able bit-period counter: one-clock tick every CLKS_PER_BIT enabled clocks.
module screen_baud_tick #(
  parameter int CLKS_PER_BIT = screen_uart_pkg::CLKS_PER_BIT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_q;

  assign tick_o = en_i && (cnt_q == LAST);

  // Count enabled clocks, wrapping at the end of each bit cell; clear restarts a cell.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i || clr_i) cnt_q <= '0;
    else if (en_i)      cnt_q <= (cnt_q == LAST) ? 16'd0 : cnt_q + 16'd1;
  end

endmodule

// File: rtl/screen_tx.sv
// RS485 UART transmitter for the screen link, with holding register and DE guard times.
module screen_tx #(
  parameter int CLKS_PER_BIT = screen_uart_pkg::CLKS_PER_BIT,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int DE_LEAD      = 246,
  parameter int DE_TAIL      = 246
) (
  input  logic       clk_29491200Hz,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_de,
  output logic       tx_busy,
  output logic       tx_done
);
  import screen_uart_pkg::*;

  localparam int          FRAME_BITS = PARITY_EN ? FRAME_BITS_P : FRAME_BITS_NP;
  localparam logic [3:0]  LAST_BIT   = 4'(FRAME_BITS - 1);
  localparam logic [15:0] LEAD_LAST  = 16'(DE_LEAD - 1);
  localparam logic [15:0] TAIL_LAST  = 16'(DE_TAIL - 1);

  tx_state_e   state_q;
  logic [7:0]  hold_q;
  logic        hold_full_q;
  logic [9:0]  shreg_q;     // bits still to send after the one on tx_out_q
  logic [3:0]  bit_cnt_q;
  logic [15:0] guard_q;     // LEAD / TAIL clock counter
  logic        tx_out_q;
  logic        tx_de_q;
  logic        tx_done_q;

  logic        tick;
  logic        accept;
  logic        load;
  logic        frame_end;
  logic [10:0] frame_d;

  screen_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_i  (clk_29491200Hz),
    .rst_i  (rst),
    .clr_i  (load),
    .en_i   (state_q == ST_SHIFT),
    .tick_o (tick)
  );

  assign accept  = tx_valid && !hold_full_q;
  assign frame_d = build_frame(hold_q, PARITY_EN, PARITY_ODD);

  // Decide when the holding byte moves into the shifter and when a stop bit ends.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    frame_end = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      ST_IDLE:  load = hold_full_q && (DE_LEAD == 0);
      ST_LEAD:  load = (guard_q == LEAD_LAST);
      ST_SHIFT: begin
        frame_end = tick && (bit_cnt_q == LAST_BIT);
        load      = frame_end && hold_full_q;
      end
      ST_TAIL:  load = hold_full_q;
    endcase
  end

  // Holding register data; only meaningful while hold_full_q is set.
  always_ff @(posedge clk_29491200Hz) begin
    // NOTE: data-only register without reset; hold_full_q qualifies it.
    if (accept) hold_q <= tx_data;
  end

  // Transmit FSM with registered line, driver-enable and done outputs.
  always_ff @(posedge clk_29491200Hz) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      shreg_q     <= '1;
      bit_cnt_q   <= '0;
      guard_q     <= '0;
      tx_out_q    <= 1'b1;
      tx_de_q     <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      tx_done_q   <= frame_end;
      // A load frees the slot and an accept refills it in the same edge.
      hold_full_q <= accept || (hold_full_q && !load);

      unique case (state_q)
        ST_IDLE: begin
          if (hold_full_q && (DE_LEAD != 0)) begin
            state_q <= ST_LEAD;
            guard_q <= '0;
            tx_de_q <= 1'b1;
          end
        end
        ST_LEAD: begin
          guard_q <= guard_q + 16'd1;
        end
        ST_SHIFT: begin
          if (tick) begin
            if (bit_cnt_q == LAST_BIT) begin
              tx_out_q <= 1'b1;
              guard_q  <= '0;
              if (DE_TAIL == 0) begin
                state_q <= ST_IDLE;
                tx_de_q <= 1'b0;
              end else begin
                state_q <= ST_TAIL;
              end
            end else begin
              tx_out_q  <= shreg_q[0];
              shreg_q   <= {1'b1, shreg_q[9:1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        ST_TAIL: begin
          if (guard_q == TAIL_LAST) begin
            state_q <= ST_IDLE;
            tx_de_q <= 1'b0;
          end else begin
            guard_q <= guard_q + 16'd1;
          end
        end
      endcase

      // Loading a frame overrides whatever the state branch chose.
      if (load) begin
        state_q             <= ST_SHIFT;
        {shreg_q, tx_out_q} <= frame_d;
        bit_cnt_q           <= '0;
        tx_de_q             <= 1'b1;
      end
    end
  end

  assign tx_ready = !hold_full_q;
  assign tx_out   = tx_out_q;
  assign tx_de    = tx_de_q;
  assign tx_done  = tx_done_q;
  assign tx_busy  = (state_q != ST_IDLE) || hold_full_q;

endmodule

// File: doc/screen_tx.md
Name: screen_tx

Overview:
- RS485 UART transmitter for the screen link; counterpart of the screen receive stage, same 29.4912 MHz clock and same 246-clock bit period (~119.9 kbaud).
- Accepts bytes over valid/ready and serialises each as one frame on tx_out.
- Drives the half-duplex transceiver enable tx_de with lead/tail guard times.
- One-byte holding register allows back-to-back frames with no idle gap.

Parameters:
- CLKS_PER_BIT, 246, clocks per bit cell (range 2..65535).
- PARITY_EN, 1, 1 = 11-bit frame (start, 8 data LSB first, parity, stop); 0 = 10-bit frame (no parity).
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- DE_LEAD, 246, clocks tx_de is high before the start bit of a burst (0 allowed).
- DE_TAIL, 246, clocks tx_de stays high after the last stop bit ends (0 allowed).

Ports:
- clk_29491200Hz  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  holding register empty; byte accepted on (tx_valid && tx_ready) at posedge
- tx_out  out  1  serial line, idle high
- tx_de  out  1  RS485 driver enable
- tx_busy  out  1  high in any state other than IDLE, or while the holding register is full
- tx_done  out  1  one-clock pulse at the end of each frame's stop bit

Behaviour:
- Reset (rst high at posedge):
  - all state returns to IDLE; holding register empty.
  - tx_out=1, tx_de=0, tx_ready=1, tx_busy=0, tx_done=0.
  - A frame in flight is abandoned immediately; no partial-bit completion.
- Accept: the byte latches into the holding register; tx_ready is low from the next clock until the FSM loads the byte into the shift register.
- FSM states: IDLE, LEAD, SHIFT, TAIL.
  - IDLE -> LEAD when the holding register is full. tx_de rises on the clock after entry. If DE_LEAD=0, go straight to SHIFT.
  - LEAD: count DE_LEAD clocks, then -> SHIFT.
  - SHIFT entry: load the shift register with {stop=1, parity, data[7:0], start=0}, clear the holding register (tx_ready=1 next clock), and reset the bit and clk counters.
  - SHIFT timing: tx_out is registered and presents each bit for exactly CLKS_PER_BIT clocks. The first tx_out=0 appears one clock after SHIFT entry.
  - Parity: XOR of data bits, inverted when PARITY_ODD=1.
- End of stop bit (clk counter = CLKS_PER_BIT-1 and bit counter = last):
  - tx_done pulses for that clock.
  - If the holding register is full, reload and stay in SHIFT. The next start bit follows the stop bit with zero gap, and there is no new lead time.
  - Otherwise -> TAIL.
- TAIL: tx_out=1, tx_de=1.
  - After DE_TAIL clocks -> IDLE and tx_de=0.
  - A byte accepted during TAIL -> SHIFT directly on the next clock, with no lead; tx_de stays high.
  - If DE_TAIL=0, go from SHIFT straight to IDLE.
- tx_de is high in LEAD, SHIFT and TAIL, low only in IDLE. There are no glitches between back-to-back frames.
- Simultaneous accept and load in the same clock: the load has priority. The holding register frees at the clock edge and the new byte is written in the same edge. tx_ready=1 during that clock is legal.
- tx_valid while tx_ready=0 is ignored. The upstream holds tx_data/tx_valid until accepted.
- Counters:
  - clk counter is 16-bit and wraps at CLKS_PER_BIT-1.
  - bit counter is 4-bit and stops at 10 (PARITY_EN=1) or 9.
  - No free-running wrap.
- Frame length: 11*CLKS_PER_BIT = 2706 clocks with parity; 2460 without.

Decomposition:
- Shared package screen_uart_pkg holds:
  - CLKS_PER_BIT default 246.
  - Frame-length constants FRAME_BITS_P=11 and FRAME_BITS_NP=10.
  - FSM state encoding (2-bit IDLE/LEAD/SHIFT/TAIL).
  - Its bit-period constant is the one the receive stage uses.
- One natural sub-module: screen_baud_tick, a clear-able clock-cycle counter producing a one-clock tick every CLKS_PER_BIT clocks. It is reusable by the receive side.
- FSM, shifter, holding register and DE control stay in screen_tx.

Test Plan:
- Reset then send 0xA5 (PARITY_EN=1, even):
  - tx_de rises, then 246 clocks later tx_out carries 0,1,0,1,0,0,1,0,1,0,1, each 246 clocks.
  - tx_done pulses once at 246*12 clocks after tx_de rose.
  - tx_de falls 246 clocks after that.
- Back-to-back 0x00 then 0xFF, second offered while the first is in SHIFT:
  - No gap between the first stop and the second start.
  - Second frame parity=0; tx_de continuous high; exactly two tx_done pulses.
- Byte 0x3C offered 100 clocks into TAIL:
  - SHIFT restarts next clock with no lead.
  - tx_de never drops; start bit begins within 2 clocks.
- PARITY_ODD=1, byte 0x01: parity bit = 0. PARITY_EN=0: frame is 2460 clocks and tx_done occurs at bit 9 end.
- rst asserted mid-data-bit 4 of 0x55: tx_out=1, tx_de=0 and tx_ready=1 on the next clock. No tx_done. A new byte afterwards transmits normally.
- tx_valid held high with tx_ready low for 500 clocks:
  - Only one byte accepted per free slot.
  - Data changes while tx_ready=0 never appear on the line.
